ram_bank_4002: RTL
==================

Name: ram_bank_4002

Overview:
- 4002-style data RAM and output-port chip on the CPU's nibble bus, directly downstream of the CPU core.
- Consumes the CPU's sync, one ram_cmd_n line and the shared 4-bit bus, and returns read data on the same bus.
- Holds 4 registers × (16 main + 4 status) nibbles plus a 4-bit output port.
- Up to four instances share one command line, distinguished by CHIP_ID.

Parameters:
CHIP_ID, 2'd0, chip number matched against bits [3:2] of the SRC high nibble

Ports:
clock    input   1  system clock
reset_n  input   1  asynchronous, active-low reset
halt     input   1  freeze: all state holds while high
sync     input   1  CPU sync; high during X3, next clock is A1
cmd_n    input   1  one ram_cmd_n bit from CPU, active-low
data_i   input   4  bus nibble from CPU/ROM
data_o   output  4  read data; 4'h0 when data_en low
data_en  output  1  high when this chip drives the bus
port_o   output  4  registered output port (WMP target)

Behaviour:
- Reset is asynchronous on reset_n low. It clears every flop:
  - phase=0, synced=0, selected=0, reg_addr=0, char_addr=0, io_active=0, opa=0
  - all 80 memory nibbles=0, port_o=0
  - combinational outputs: data_en=0, data_o=0
- Reset asserted mid-cycle aborts any operation. The block stays idle (synced=0) until the next sync.
- Phase counter (3 bits): 0=A1, 1=A2, 2=A3, 3=M1, 4=M2, 5=X1, 6=X2, 7=X3.
  - sync high at a clock edge: phase<=0, synced<=1 (this resyncs from any phase).
  - Otherwise phase<=phase+1, wrapping 7->0.
  - halt high: nothing updates, sync included.
- All decode below is gated by synced=1 and halt=0.
- A3 (phase 2): io_pend<=~cmd_n.
- M1 (phase 3): io_active<=io_pend & (data_i==4'hE).
- M2 (phase 4): opa<=data_i.
- X2 (phase 6), io_active=1:
  - The instruction is an I/O op. cmd_n is ignored.
  - The op executes only if selected=1.
- X2 (phase 6), io_active=0 and cmd_n=0 (SRC):
  - selected<=(data_i[3:2]==CHIP_ID), reg_addr<=data_i[1:0], src_flag<=1.
- X3 (phase 7): if src_flag, char_addr<=data_i. src_flag is then cleared; io_active is cleared.
- I/O ops, effective at the X2 edge, indexed by reg_addr/char_addr:
  - opa 0 (WRM): main[reg][char]<=data_i
  - opa 1 (WMP): port_o<=data_i
  - opa 4-7 (WR0-3): status[reg][opa-4]<=data_i
  - opa 8 (SBM), 9 (RDM), B (ADM): data_en=1 throughout X2, data_o=main[reg][char]
  - opa C-F (RD0-3): data_en=1 throughout X2, data_o=status[reg][opa-C]
  - opa 2, 3, A: ignored; bus not driven.
- Read path is combinational from the registered address/opa during phase 6. Zero added latency: the CPU samples the data at the end of X2.
- A deselected chip (selected=0) never writes and never drives data_en.
- selected, reg_addr and char_addr persist across instructions until the next SRC.
- data_en is never high outside phase 6.

Optional Feature:
STATUS_CHARS_EN
- Defined: status nibbles implemented as above.
- Undefined:
  - No status storage; WR0-3 are ignored.
  - RD0-3 leave data_en=0.
  - Memory shrinks to 64 nibbles.
  - All other behaviour is unchanged.

Test Plan:
- Reset/idle: reset_n low mid-X2 of an RDM -> data_en=0 immediately; port_o=0; no bus activity until first sync.
- SRC + WRM + RDM (CHIP_ID=1): SRC with X2 nibble 4'h6, X3 nibble 4'hA; then WRM (M1=E, M2=0, cmd_n low at A3, X2 data 4'h5); then RDM -> data_en=1 only in X2, data_o=4'h5; main[2][A]=5.
- Chip select miss: SRC with X2 nibble 4'h2 (chip 0) into CHIP_ID=1 instance, then WRM 4'h7 and RDM -> no write, data_en stays 0.
- WMP: selected chip, M2=1, X2 data 4'hC -> port_o=4'hC from the X2 edge, held across later cycles.
- Status chars: WR2 with data 4'h9, then RD2 -> data_o=4'h9 in X2 (with STATUS_CHARS_EN); without the macro -> data_en=0.
- Halt/resync: halt high for 3 clocks in M1 -> phase frozen, then resumes; sync pulsed at phase 3 -> next phase 0; opcode E without cmd_n low at A3 -> no I/O action.

Source files
------------

// File: rtl/ram_bank_4002.sv
// 4002-style data RAM / output port on the nibble bus: 4 registers x 16 main nibbles,
// optional 4 status nibbles per register (STATUS_CHARS_EN), and a 4-bit output port.
//
// state | meaning
// A1    | address nibble 1 from ROM
// A2    | address nibble 2
// A3    | address nibble 3; cmd_n low here marks a pending I/O instruction
// M1    | opcode high nibble (E selects the I/O group)
// M2    | opcode low nibble, latched as opa
// X1    | execute 1 (unused here)
// X2    | execute 2: SRC chip/register select, or I/O write/read
// X3    | execute 3: SRC character address; sync high here
module ram_bank_4002 #(
  parameter logic [1:0] CHIP_ID = 2'd0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       halt,
  input  logic       sync,
  input  logic       cmd_n,
  input  logic [3:0] data_i,
  output logic [3:0] data_o,
  output logic       data_en,
  output logic [3:0] port_o
);

  typedef enum logic [2:0] {
    PH_A1 = 3'd0,
    PH_A2 = 3'd1,
    PH_A3 = 3'd2,
    PH_M1 = 3'd3,
    PH_M2 = 3'd4,
    PH_X1 = 3'd5,
    PH_X2 = 3'd6,
    PH_X3 = 3'd7
  } phase_t;

  phase_t     phase;
  phase_t     phase_nxt;
  logic       synced;
  logic       synced_nxt;

  logic       io_pend;
  logic       io_active;
  logic       src_flag;
  logic       selected;
  logic [1:0] reg_addr;
  logic [3:0] char_addr;
  logic [3:0] opa;

  logic       decode_en;
  logic       io_exec;
  logic [5:0] main_idx;

  logic [3:0] main_mem [64];

  assign decode_en = synced & ~halt;
  assign io_exec   = decode_en & (phase == PH_X2) & io_active & selected;
  assign main_idx  = {reg_addr, char_addr};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase  <= PH_A1;
      synced <= 1'b0;
    end else begin
      phase  <= phase_nxt;
      synced <= synced_nxt;
    end
  end

  // sync wins over the free-running count so a stray sync realigns the chip at once
  always_comb begin
    phase_nxt  = phase;
    synced_nxt = synced;
    if (!halt) begin
      if (sync) begin
        phase_nxt  = PH_A1;
        synced_nxt = 1'b1;
      end else begin
        phase_nxt = phase_t'(3'(phase + 3'd1));
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      io_pend   <= 1'b0;
      io_active <= 1'b0;
      src_flag  <= 1'b0;
      selected  <= 1'b0;
      reg_addr  <= 2'd0;
      char_addr <= 4'd0;
      opa       <= 4'd0;
    end else if (decode_en) begin
      case (phase)
        PH_A3: io_pend <= ~cmd_n;
        PH_M1: io_active <= io_pend & (data_i == 4'hE);
        PH_M2: opa <= data_i;
        PH_X2: begin
          // during an I/O instruction cmd_n is not a SRC strobe
          if (!io_active && !cmd_n) begin
            selected <= (data_i[3:2] == CHIP_ID);
            reg_addr <= data_i[1:0];
            src_flag <= 1'b1;
          end
        end
        PH_X3: begin
          if (src_flag) char_addr <= data_i;
          src_flag  <= 1'b0;
          io_active <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 64; i++) main_mem[i] <= 4'd0;
    end else if (io_exec && (opa == 4'h0)) begin
      main_mem[main_idx] <= data_i;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      port_o <= 4'd0;
    end else if (io_exec && (opa == 4'h1)) begin
      port_o <= data_i;
    end
  end

`ifdef STATUS_CHARS_EN
  logic [3:0] stat_mem [16];
  logic [3:0] stat_idx;

  assign stat_idx = {reg_addr, opa[1:0]};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) stat_mem[i] <= 4'd0;
    end else if (io_exec && (opa[3:2] == 2'b01)) begin
      stat_mem[stat_idx] <= data_i;
    end
  end
`endif

  // read data is purely combinational so the CPU can sample it at the end of X2
  always_comb begin
    data_en = 1'b0;
    data_o  = 4'd0;
    if (io_exec) begin
      case (opa)
        4'h8, 4'h9, 4'hB: begin
          data_en = 1'b1;
          data_o  = main_mem[main_idx];
        end
`ifdef STATUS_CHARS_EN
        4'hC, 4'hD, 4'hE, 4'hF: begin
          data_en = 1'b1;
          data_o  = stat_mem[stat_idx];
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
